gpio_probe_scanner: RTL and testbench
=====================================

# gpio_probe_scanner

Sequencer that probes an unknown circuit on GPIO_0 pins to find gate connections. Each candidate pin in turn is driven low, then high, while all other candidate pins are sampled. The block reports which pins followed or inverted the driven pin. It sits downstream of the clock divider, consuming its slow tick as a settle-time enable, and upstream of the LED/readout logic that displays each result map.

## Interface
- `N_PINS`, default 6: number of candidate pins probed; legal range 2..36.
- `SETTLE`, default 16: ticks waited per drive phase before sampling; must be at least 2.
- `clk` in 1: system clock (CLOCK_50 domain).
- `reset_n` in 1: asynchronous, active-low reset.
- `tick` in 1: single-`clk`-cycle enable from the clock divider; all settle counting advances only on it.
- `start` in 1: level-sampled request to begin a scan; acted on only in IDLE.
- `pin_in` in N_PINS: raw pad inputs (asynchronous).
- `drive_oe` out N_PINS: per-pin output enable; one-hot or zero.
- `drive_val` out N_PINS: per-pin drive value; non-source bits are 0.
- `busy` out 1: high from start acceptance until return to IDLE.
- `done` out 1: one-`clk` pulse when the final result is accepted.
- `result_valid` out 1: result_src/result_map hold a valid result.
- `result_ready` in 1: consumer accepts the result when it is high together with result_valid.
- `result_src` out clog2(N_PINS): index of the pin that was driven.
- `result_map` out N_PINS: pins that toggled with the source; the bit at result_src is always 0.

## Operation
- `pin_in` passes through a 2-flop synchronizer on `clk`, always present; all sampling uses the synchronized value `pin_s`.
- States: IDLE, DRIVE_LO, DRIVE_HI, REPORT.
- **IDLE:** outputs are quiet. On `start`=1, load src=0, clear the tick counter, and go to DRIVE_LO.
- **DRIVE_LO:**
  - drive_oe = 1<<src; drive_val = 0.
  - The counter increments on each tick.
  - On the tick where the counter reaches SETTLE, capture s0 = pin_s, clear the counter, and go to DRIVE_HI.
- **DRIVE_HI:**
  - drive_val = 1<<src.
  - Same counting as DRIVE_LO; at SETTLE, capture s1 = pin_s.
  - Compute result_map = (s0 ^ s1) & ~(1<<src), set result_valid, and go to REPORT.
- **REPORT:**
  - drive_oe = 0, so the source is released.
  - Hold the result stable until result_valid && result_ready.
  - On acceptance, clear result_valid. If src == N_PINS-1, pulse `done` and go to IDLE; otherwise increment src, clear the counter, and go to DRIVE_LO.
- `start` outside IDLE is ignored.
- `tick` in REPORT or IDLE is ignored.
- Width rules: the counter is clog2(SETTLE+1) bits and never wraps past SETTLE. `src` never exceeds N_PINS-1.
- Exactly one drive_oe bit is high in DRIVE_LO and DRIVE_HI, and none elsewhere. The block never drives two pins at once.

## Timing
- Reset values: drive_oe=0, drive_val=0, busy=0, done=0, result_valid=0, result_src=0, result_map=0, state=IDLE, counter=0, synchronizer flops=0.
- Asserting `reset_n` low mid-scan releases all pins (drive_oe=0) immediately and asynchronously.
- All outputs are registered.
- drive_oe and busy rise 1 `clk` after the cycle in which `start` is sampled in IDLE.
- Input path latency is 2 `clk` cycles through the synchronizer. The first tick after a drive change therefore sees at most 2 cycles of stale data. SETTLE ≥ 2 covers this when the tick period is greater than 1 `clk`.
- result_valid rises 1 `clk` after the SETTLE-th tick of DRIVE_HI.
- The next DRIVE_LO begins the `clk` after acceptance.
- `done` pulses on the same edge on which result_valid falls for the last source.
- If `tick` and acceptance fall in the same cycle, the tick is discarded; counting starts fresh in DRIVE_LO.
- Per-source minimum is 2·SETTLE ticks plus 2 `clk` cycles, plus any ready stall.

## Configuration
- **Macro name:** `SCAN_DOUBLE_SAMPLE_EN`.
- **When defined:** each phase also samples pin_s on tick SETTLE-1.
  - A pin bit is credited in result_map only if both samples agree within the DRIVE_LO phase and both agree within the DRIVE_HI phase.
  - A pin whose samples disagree within a phase is forced to 0 (treated as unstable).
- **When undefined:** a single sample is taken at SETTLE, as described above. The port list is identical in both builds.

## Test plan
All scenarios use N_PINS=6, SETTLE=4, `tick` every 3rd `clk`, and result_ready held at 1 unless stated. The bench models: pin1 = pin0 (wire); pin3 = NOT pin2 when drive_oe[3]=0; pins 4 and 5 pulled to 1.
1. Full scan → results in order:
   - src0: map 6'b000010
   - src1: map 6'b000001
   - src2: map 6'b001000
   - src3: map 6'b000000
   - src4: map 6'b000000
   - src5: map 6'b000000
   - then `done` for 1 `clk`, busy=0.
2. Hold result_ready=0 for 50 `clk` at src2 → result_valid, src=2, and map=6'b001000 all stay stable, and drive_oe=0 throughout the stall.
3. Pulse `start` during DRIVE_HI of src1 → ignored; scan order and results are unchanged, with exactly one `done`.
4. Deassert reset_n mid-DRIVE_LO of src3 → drive_oe=0 in the same cycle without a `clk` edge. After release: IDLE, busy=0, result_valid=0.
5. Count check: exactly 4 ticks elapse between drive_oe rising for src0 and the DRIVE_HI transition. drive_oe is one-hot in every cycle of both drive states.
6. With `SCAN_DOUBLE_SAMPLE_EN` defined, make pin1 follow pin0 only after a 3-tick delay → src0 map=6'b000000. Without the macro, the same stimulus gives map=6'b000010.

Source files
------------

// File: rtl/gpio_probe_scanner.sv
// GPIO probe sequencer: drives each candidate pin low then high and reports which other pins followed.
// Optional build macro SCAN_DOUBLE_SAMPLE_EN adds a second sample per phase to reject unstable pins.
module gpio_probe_scanner #(
    parameter int unsigned N_PINS = 6,
    parameter int unsigned SETTLE = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      tick,
    input  logic                      start,
    input  logic [N_PINS-1:0]         pin_in,
    output logic [N_PINS-1:0]         drive_oe,
    output logic [N_PINS-1:0]         drive_val,
    output logic                      busy,
    output logic                      done,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [$clog2(N_PINS)-1:0] result_src,
    output logic [N_PINS-1:0]         result_map
);

    localparam int unsigned CW = $clog2(SETTLE + 1);
    localparam int unsigned SW = $clog2(N_PINS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE_LO,
        ST_DRIVE_HI,
        ST_REPORT
    } state_e;

    state_e              state_q, state_d;
    logic [N_PINS-1:0]   sync1_q, pin_s_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SW-1:0]       src_q, src_d;
    logic [N_PINS-1:0]   s0_q, s0_d;
    logic [N_PINS-1:0]   oe_q, oe_d;
    logic [N_PINS-1:0]   val_q, val_d;
    logic [N_PINS-1:0]   map_q, map_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                rv_q, rv_d;
`ifdef SCAN_DOUBLE_SAMPLE_EN
    logic [N_PINS-1:0]   s0a_q, s0a_d;
    logic [N_PINS-1:0]   s1a_q, s1a_d;
    logic [N_PINS-1:0]   lo_ok_q, lo_ok_d;
`endif

    logic [N_PINS-1:0]   src_bit;
    logic [N_PINS-1:0]   next_bit;
    logic                last_tick;
    logic                early_tick;

    assign src_bit    = N_PINS'(1) << src_q;
    assign next_bit   = N_PINS'(1) << (src_q + SW'(1));
    assign last_tick  = tick && (cnt_q == CW'(SETTLE - 1));
    assign early_tick = tick && (cnt_q == CW'(SETTLE - 2));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            pin_s_q <= '0;
        end else begin
            sync1_q <= pin_in;
            pin_s_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            s0_q    <= '0;
            oe_q    <= '0;
            val_q   <= '0;
            map_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rv_q    <= 1'b0;
`ifdef SCAN_DOUBLE_SAMPLE_EN
            s0a_q   <= '0;
            s1a_q   <= '0;
            lo_ok_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            s0_q    <= s0_d;
            oe_q    <= oe_d;
            val_q   <= val_d;
            map_q   <= map_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rv_q    <= rv_d;
`ifdef SCAN_DOUBLE_SAMPLE_EN
            s0a_q   <= s0a_d;
            s1a_q   <= s1a_d;
            lo_ok_q <= lo_ok_d;
`endif
        end
    end

    // Drive outputs are computed one state ahead so every port comes straight from a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        s0_d    = s0_q;
        oe_d    = oe_q;
        val_d   = val_q;
        map_d   = map_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rv_d    = rv_q;
`ifdef SCAN_DOUBLE_SAMPLE_EN
        s0a_d   = s0a_q;
        s1a_d   = s1a_q;
        lo_ok_d = lo_ok_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d   = '0;
                    cnt_d   = '0;
                    oe_d    = N_PINS'(1);
                    val_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_DRIVE_LO;
                end
            end
            ST_DRIVE_LO: begin
                if (last_tick) begin
                    s0_d    = pin_s_q;
                    cnt_d   = '0;
                    val_d   = src_bit;
                    state_d = ST_DRIVE_HI;
`ifdef SCAN_DOUBLE_SAMPLE_EN
                    lo_ok_d = ~(s0a_q ^ pin_s_q);
`endif
                end else if (tick) begin
                    cnt_d = cnt_q + CW'(1);
`ifdef SCAN_DOUBLE_SAMPLE_EN
                    if (early_tick) s0a_d = pin_s_q;
`endif
                end
            end
            ST_DRIVE_HI: begin
                if (last_tick) begin
`ifdef SCAN_DOUBLE_SAMPLE_EN
                    map_d = (s0_q ^ pin_s_q) & ~src_bit & lo_ok_q & ~(s1a_q ^ pin_s_q);
`else
                    map_d = (s0_q ^ pin_s_q) & ~src_bit;
`endif
                    rv_d    = 1'b1;
                    oe_d    = '0;
                    val_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_REPORT;
                end else if (tick) begin
                    cnt_d = cnt_q + CW'(1);
`ifdef SCAN_DOUBLE_SAMPLE_EN
                    if (early_tick) s1a_d = pin_s_q;
`endif
                end
            end
            ST_REPORT: begin
                if (rv_q && result_ready) begin
                    rv_d = 1'b0;
                    if (src_q == SW'(N_PINS - 1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        src_d   = src_q + SW'(1);
                        cnt_d   = '0;
                        oe_d    = next_bit;
                        state_d = ST_DRIVE_LO;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign drive_oe     = oe_q;
    assign drive_val    = val_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = rv_q;
    assign result_src   = src_q;
    assign result_map   = map_q;

endmodule

// File: tb/tb_gpio_probe_scanner.sv
// Scoreboard bench for gpio_probe_scanner: N_PINS=6, SETTLE=4, tick every third clk, modelled pin network.
module tb_gpio_probe_scanner;

    localparam int unsigned N = 6;
    localparam int unsigned S = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         tick = 1'b0;
    logic         start;
    logic [N-1:0] pin_in;
    logic [N-1:0] drive_oe;
    logic [N-1:0] drive_val;
    logic         busy;
    logic         done;
    logic         result_valid;
    logic         result_ready;
    logic [2:0]   result_src;
    logic [N-1:0] result_map;

    int           errors = 0;
    int           checks = 0;
    int           done_cnt = 0;
    logic [8:0]   exp_q[$];

    logic         delay_mode = 1'b0;
    logic         p1_del = 1'b0;
    int           dcnt = 0;
    logic         p0_net;

    gpio_probe_scanner #(.N_PINS(N), .SETTLE(S)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick         (tick),
        .start        (start),
        .pin_in       (pin_in),
        .drive_oe     (drive_oe),
        .drive_val    (drive_val),
        .busy         (busy),
        .done         (done),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_src   (result_src),
        .result_map   (result_map)
    );

    always #5 clk = ~clk;

    // Pin network: pin1 wired to pin0, pin3 = ~pin2 unless driven, pins 4/5 pulled up.
    assign p0_net = drive_oe[0] ? drive_val[0] : ((drive_oe[1] && !delay_mode) ? drive_val[1] : 1'b0);
    always_comb begin
        pin_in    = '0;
        pin_in[0] = p0_net;
        pin_in[1] = drive_oe[1] ? drive_val[1] : (delay_mode ? p1_del : p0_net);
        pin_in[2] = drive_oe[2] ? drive_val[2] : 1'b0;
        pin_in[3] = drive_oe[3] ? drive_val[3] : ~pin_in[2];
        pin_in[4] = drive_oe[4] ? drive_val[4] : 1'b1;
        pin_in[5] = drive_oe[5] ? drive_val[5] : 1'b1;
    end

    // Delayed follower: pin1 takes pin0's value on the third tick after they diverge.
    always @(posedge clk) begin
        if (!delay_mode) begin
            p1_del <= 1'b0;
            dcnt   <= 0;
        end else if (p0_net != p1_del) begin
            if (tick) begin
                if (dcnt == 2) begin
                    p1_del <= p0_net;
                    dcnt   <= 0;
                end else begin
                    dcnt <= dcnt + 1;
                end
            end
        end else begin
            dcnt <= 0;
        end
    end

    initial begin : tick_gen
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            ph   = (ph == 2) ? 0 : ph + 1;
            tick = (ph == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each accepted result and checks drive invariants every cycle.
    initial begin : monitor
        logic [8:0]   e;
        logic [N-1:0] prev_val;
        logic         prev_rv;
        int           lo_ticks;
        int           hi_ticks;
        prev_val = '0;
        prev_rv  = 1'b0;
        lo_ticks = 0;
        hi_ticks = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_val = '0;
                prev_rv  = 1'b0;
                lo_ticks = 0;
                hi_ticks = 0;
            end else begin
                if (result_valid && result_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got src %0d map %b, expected none", result_src, result_map);
                    end else begin
                        e = exp_q.pop_front();
                        check("result_src", 32'(result_src), 32'(e[8:6]));
                        check("result_map", 32'(result_map), 32'(e[5:0]));
                    end
                end
                if (done) begin
                    done_cnt++;
                    check("done_busy_low", 32'(busy), 32'd0);
                    check("done_valid_low", 32'(result_valid), 32'd0);
                end
                if (drive_oe != '0) check("oe_onehot", 32'($onehot(drive_oe)), 32'd1);
                check("val_within_oe", 32'(drive_val & ~drive_oe), 32'd0);
                if (drive_val != '0 && prev_val == '0) begin
                    check("lo_ticks", 32'(lo_ticks), 32'(S));
                    lo_ticks = 0;
                end
                if (result_valid && !prev_rv) begin
                    check("hi_ticks", 32'(hi_ticks), 32'(S));
                    hi_ticks = 0;
                end
                if (drive_oe != '0 && drive_val == '0 && tick) lo_ticks++;
                if (drive_val != '0 && tick) hi_ticks++;
                prev_val = drive_val;
                prev_rv  = result_valid;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic push_exp(input int s, input logic [N-1:0] m);
        exp_q.push_back({3'(s), m});
    endtask

    task automatic push_full_scan();
        push_exp(0, 6'b000010);
        push_exp(1, 6'b000001);
        push_exp(2, 6'b001000);
        push_exp(3, 6'b000000);
        push_exp(4, 6'b000000);
        push_exp(5, 6'b000000);
    endtask

    task automatic wait_oe(input logic [N-1:0] v, input string name);
        int k;
        k = 0;
        while (drive_oe !== v && k < 2000) begin
            step(1);
            k++;
        end
        check(name, 32'(drive_oe), 32'(v));
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 2000) begin
            step(1);
            k++;
        end
        check(name, 32'(busy), 32'd0);
        step(3);
    endtask

    task automatic wait_empty(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 2000) begin
            step(1);
            k++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int k;
        reset_n      = 1'b0;
        start        = 1'b0;
        result_ready = 1'b1;
        step(3);
        check("rst_oe", 32'(drive_oe), 32'd0);
        check("rst_val", 32'(drive_val), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_src", 32'(result_src), 32'd0);
        check("rst_map", 32'(result_map), 32'd0);
        reset_n = 1'b1;
        step(2);

        // Full scan, including start-to-drive latency.
        done_cnt = 0;
        push_full_scan();
        pulse_start();
        step(1);
        check("start_oe", 32'(drive_oe), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        wait_idle("scan1_idle");
        check("scan1_done_count", 32'(done_cnt), 32'd1);
        check("scan1_drained", 32'(exp_q.size()), 32'd0);

        // Consumer stall on src2.
        done_cnt = 0;
        push_full_scan();
        pulse_start();
        wait_oe(6'b000100, "scan2_reach_src2");
        result_ready = 1'b0;
        k = 0;
        while (result_valid !== 1'b1 && k < 2000) begin
            step(1);
            k++;
        end
        repeat (50) begin
            check("stall_valid", 32'(result_valid), 32'd1);
            check("stall_src", 32'(result_src), 32'd2);
            check("stall_map", 32'(result_map), 32'b001000);
            check("stall_oe", 32'(drive_oe), 32'd0);
            step(1);
        end
        result_ready = 1'b1;
        wait_idle("scan2_idle");
        check("scan2_done_count", 32'(done_cnt), 32'd1);
        check("scan2_drained", 32'(exp_q.size()), 32'd0);

        // Start pulse during DRIVE_HI of src1 must be ignored.
        done_cnt = 0;
        push_full_scan();
        pulse_start();
        wait_oe(6'b000010, "scan3_reach_src1");
        k = 0;
        while (drive_val !== 6'b000010 && k < 2000) begin
            step(1);
            k++;
        end
        check("scan3_hi_src1", 32'(drive_val), 32'b000010);
        pulse_start();
        wait_idle("scan3_idle");
        check("scan3_done_count", 32'(done_cnt), 32'd1);
        check("scan3_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset during DRIVE_LO of src3.
        push_exp(0, 6'b000010);
        push_exp(1, 6'b000001);
        push_exp(2, 6'b001000);
        pulse_start();
        wait_oe(6'b001000, "scan4_reach_src3");
        check("scan4_lo", 32'(drive_val), 32'd0);
        step(2);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_release_oe", 32'(drive_oe), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        step(2);
        reset_n = 1'b1;
        step(2);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_valid", 32'(result_valid), 32'd0);
        check("post_rst_oe", 32'(drive_oe), 32'd0);
        check("scan4_drained", 32'(exp_q.size()), 32'd0);

        // Slow follower on pin1: unstable in double-sample builds, credited otherwise.
        delay_mode = 1'b1;
        step(2);
`ifdef SCAN_DOUBLE_SAMPLE_EN
        push_exp(0, 6'b000000);
`else
        push_exp(0, 6'b000010);
`endif
        pulse_start();
        wait_empty("scan6_src0_result");
        reset_n = 1'b0;
        step(2);
        delay_mode = 1'b0;
        reset_n    = 1'b1;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
